// File: rtl/sram_be_init.sv
// Single-port data SRAM with byte write enables, a 1- or 2-stage registered
// read pipeline, selectable read-during-write behaviour and a clear engine
// that zeroes the whole array one word per clock after reset.
module sram_be_init #(
    parameter int D_SIZE      = 32,
    parameter int A_SIZE      = 10,
    parameter int RD_LATENCY  = 1,
    parameter int WRITE_FIRST = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  read,
    input  logic                  write,
    input  logic [A_SIZE-1:0]     address,
    input  logic [D_SIZE-1:0]     data_in,
    input  logic [D_SIZE/8-1:0]   byte_en,
    output logic [D_SIZE-1:0]     data_out,
    output logic                  data_valid,
    output logic                  ready,
    output logic                  busy_err
);

    localparam int DEPTH = 1 << A_SIZE;
    localparam int NB    = D_SIZE / 8;

    typedef enum logic {
        INIT,
        READY
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [A_SIZE-1:0]   cnt;
    logic [A_SIZE-1:0]   cnt_next;

    logic [D_SIZE-1:0]   mem [DEPTH];

    logic                accept_rd;
    logic                accept_wr;
    logic [D_SIZE-1:0]   old_word;
    logic [D_SIZE-1:0]   merged_word;
    logic [D_SIZE-1:0]   rd_word;

    logic                stage1_valid;
    logic [D_SIZE-1:0]   stage1_data;

    // FSM state and sweep counter; reset restarts the clear sweep at word 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic: INIT walks every word once, READY is terminal
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            INIT: begin
                cnt_next = cnt + 1'b1;
                if (cnt == {A_SIZE{1'b1}}) begin
                    state_next = READY;
                end
            end
            READY: begin
                state_next = READY;
            end
            default: begin
                state_next = INIT;
            end
        endcase
    end

    assign ready     = (state == READY);
    assign accept_rd = ready && read;
    assign accept_wr = ready && write;

    // Byte merge of the addressed word and the read-during-write selection
    always_comb begin
        old_word    = mem[address];
        merged_word = old_word;
        for (int k = 0; k < NB; k++) begin
            if (byte_en[k]) begin
                merged_word[8*k +: 8] = data_in[8*k +: 8];
            end
        end
        rd_word = ((WRITE_FIRST != 0) && accept_wr) ? merged_word : old_word;
    end

    // Array port: the clear engine owns it during INIT, user writes after
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[cnt] <= '0;
        end else if (accept_wr) begin
            mem[address] <= merged_word;
        end
    end

    // Requests that arrive before the sweep finishes are flagged next cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_err <= 1'b0;
        end else begin
            busy_err <= (state == INIT) && (read || write);
        end
    end

    // First read stage captures the data itself so later writes cannot alter it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage1_valid <= 1'b0;
            stage1_data  <= '0;
        end else begin
            stage1_valid <= accept_rd;
            stage1_data  <= accept_rd ? rd_word : '0;
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic              stage2_valid;
            logic [D_SIZE-1:0] stage2_data;

            // Optional second stage for a two-cycle read latency
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stage2_valid <= 1'b0;
                    stage2_data  <= '0;
                end else begin
                    stage2_valid <= stage1_valid;
                    stage2_data  <= stage1_data;
                end
            end

            assign data_valid = stage2_valid;
            assign data_out   = stage2_data;
        end else begin : g_lat1
            assign data_valid = stage1_valid;
            assign data_out   = stage1_data;
        end
    endgenerate

endmodule

// File: tb/tb_sram_be_init.sv
// Scoreboard bench for sram_be_init: two instances share stimulus, one with
// 1-cycle latency and write-first, one with 2-cycle latency and read-first.
module tb_sram_be_init;

    localparam int DEPTH = 1024;

    logic        clk;
    logic        rst_n;
    logic        read;
    logic        write;
    logic [9:0]  address;
    logic [31:0] data_in;
    logic [3:0]  byte_en;

    logic [31:0] dout_a, dout_b;
    logic        dv_a, dv_b, rdy_a, rdy_b, berr_a, berr_b;

    typedef struct {
        logic [31:0] data;
        int          at;
    } exp_t;

    exp_t        q_a[$];
    exp_t        q_b[$];
    logic [31:0] model [DEPTH];

    int cyc       = 0;
    int sweep     = 0;
    bit busy_pend = 0;
    int checks    = 0;
    int passed    = 0;

    sram_be_init #(.D_SIZE(32), .A_SIZE(10), .RD_LATENCY(1), .WRITE_FIRST(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .read(read), .write(write), .address(address),
        .data_in(data_in), .byte_en(byte_en), .data_out(dout_a),
        .data_valid(dv_a), .ready(rdy_a), .busy_err(berr_a)
    );

    sram_be_init #(.D_SIZE(32), .A_SIZE(10), .RD_LATENCY(2), .WRITE_FIRST(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .read(read), .write(write), .address(address),
        .data_in(data_in), .byte_en(byte_en), .data_out(dout_b),
        .data_valid(dv_b), .ready(rdy_b), .busy_err(berr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    // Edge bookkeeping: cycle count, sweep progress and expected busy pulse
    always @(posedge clk) begin
        cyc++;
        busy_pend = rst_n && (sweep < DEPTH) && (read || write);
        if (!rst_n) sweep = 0;
        else if (sweep < DEPTH) sweep++;
    end

    task automatic monitor_port(input int p, input logic dv, input logic [31:0] d);
        exp_t  e;
        bit    due;
        string tag;
        tag = (p == 0) ? "a" : "b";
        if (p == 0) due = (q_a.size() > 0) && (q_a[0].at == cyc);
        else        due = (q_b.size() > 0) && (q_b[0].at == cyc);
        check_output($sformatf("data_valid_%s", tag), {31'b0, dv}, {31'b0, due});
        if (due) begin
            if (p == 0) e = q_a.pop_front();
            else        e = q_b.pop_front();
            check_output($sformatf("data_out_%s", tag), d, e.data);
        end else begin
            check_output($sformatf("data_out_idle_%s", tag), d, 32'h0);
        end
    endtask

    // Monitor: samples both instances mid-cycle and checks against expectations
    always @(negedge clk) begin
        logic exp_ready;
        logic exp_busy;
        exp_ready = rst_n && (sweep >= DEPTH);
        exp_busy  = rst_n && busy_pend;
        check_output("ready_a", {31'b0, rdy_a}, {31'b0, exp_ready});
        check_output("ready_b", {31'b0, rdy_b}, {31'b0, exp_ready});
        check_output("busy_err_a", {31'b0, berr_a}, {31'b0, exp_busy});
        check_output("busy_err_b", {31'b0, berr_b}, {31'b0, exp_busy});
        monitor_port(0, dv_a, dout_a);
        monitor_port(1, dv_b, dout_b);
    end

    // Drive one cycle of stimulus and update the reference model/scoreboard
    task automatic apply_stimulus(input bit rd, input bit wr, input int addr,
                                  input logic [31:0] din, input logic [3:0] be);
        logic [31:0] old_w;
        logic [31:0] new_w;
        bit          ready_now;
        exp_t        e;
        @(posedge clk);
        #1;
        read    = rd;
        write   = wr;
        address = addr[9:0];
        data_in = din;
        byte_en = be;
        ready_now = rst_n && (sweep >= DEPTH);
        if (ready_now) begin
            old_w = model[addr];
            new_w = old_w;
            for (int k = 0; k < 4; k++) begin
                if (be[k]) new_w[8*k +: 8] = din[8*k +: 8];
            end
            if (rd) begin
                e.data = wr ? new_w : old_w;
                e.at   = cyc + 1;
                q_a.push_back(e);
                e.data = old_w;
                e.at   = cyc + 2;
                q_b.push_back(e);
            end
            if (wr) model[addr] = new_w;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, 32'h0, 4'h0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        read  = 1'b0;
        write = 1'b0;
        q_a.delete();
        q_b.delete();
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b0;
        read    = 1'b0;
        write   = 1'b0;
        address = '0;
        data_in = '0;
        byte_en = '0;
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        $display("[TB] reset released, sweep running");

        // Request during the sweep: third edge after release
        idle(2);
        apply_stimulus(0, 1, 9, 32'hCAFEF00D, 4'hF);
        idle(100);
        apply_stimulus(1, 1, 12, 32'h12345678, 4'hF);
        idle(DEPTH);

        // Cleared words at both ends and the middle, and the busy-time write
        apply_stimulus(1, 0, 0, 32'h0, 4'h0);
        apply_stimulus(1, 0, 511, 32'h0, 4'h0);
        apply_stimulus(1, 0, 1023, 32'h0, 4'h0);
        apply_stimulus(1, 0, 9, 32'h0, 4'h0);
        apply_stimulus(1, 0, 12, 32'h0, 4'h0);

        // Byte-enable merge
        apply_stimulus(0, 1, 5, 32'hDEADBEEF, 4'b1111);
        apply_stimulus(0, 1, 5, 32'h0000AB00, 4'b0010);
        apply_stimulus(1, 0, 5, 32'h0, 4'h0);
        apply_stimulus(0, 1, 6, 32'hFFFFFFFF, 4'b0000);
        apply_stimulus(1, 0, 6, 32'h0, 4'h0);

        // Read-during-write on the same address
        apply_stimulus(0, 1, 7, 32'h11111111, 4'b1111);
        apply_stimulus(1, 1, 7, 32'h22222222, 4'b1111);
        apply_stimulus(1, 0, 7, 32'h0, 4'h0);
        apply_stimulus(1, 1, 7, 32'h00330000, 4'b0100);

        // Back-to-back reads
        for (int i = 1; i <= 4; i++) apply_stimulus(0, 1, i, 32'hA0 + i, 4'hF);
        for (int i = 1; i <= 4; i++) apply_stimulus(1, 0, i, 32'h0, 4'h0);
        idle(3);

        // Randomised traffic on a small address window to force collisions
        for (int i = 0; i < 400; i++) begin
            apply_stimulus($urandom_range(0, 1), ($urandom_range(0, 9) < 4),
                           $urandom_range(0, 15), $urandom, 4'($urandom_range(0, 15)));
        end
        idle(3);

        // Reset with a read in flight, then confirm the re-sweep cleared data
        apply_stimulus(0, 1, 5, 32'h5A5A5A5A, 4'hF);
        apply_stimulus(1, 0, 5, 32'h0, 4'h0);
        do_reset();
        idle(5);
        apply_stimulus(1, 1, 3, 32'hFFFF0000, 4'hC);
        idle(DEPTH);
        apply_stimulus(1, 0, 5, 32'h0, 4'h0);
        apply_stimulus(1, 0, 3, 32'h0, 4'h0);
        idle(4);

        check_output("queue_a_drained", q_a.size(), 32'h0);
        check_output("queue_b_drained", q_b.size(), 32'h0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/sram_be_init.md
Name: sram_be_init

Overview:
Parametrised single-port data SRAM for the golden-model CPU data path. It adds four things:
- per-byte write enables;
- a configurable registered read pipeline with a valid strobe;
- selectable read-during-write policy;
- a synthesizable sequential clear engine in place of a whole-array reset.

Reset starts a sweep that zeroes every word, one per clock. Accesses are accepted only after the sweep completes.

Parameters:
D_SIZE, 32, data width in bits; must be a multiple of 8.
A_SIZE, 10, address width; DEPTH = 1<<A_SIZE words.
RD_LATENCY, 1, read latency in cycles; legal values 1 or 2.
WRITE_FIRST, 1, same-address read+write: 1 = return new data, 0 = return old data.

Ports:
clk  input  1  clock, all state on rising edge.
rst_n  input  1  reset, asynchronous, active-low.
read  input  1  read request, active 1.
write  input  1  write request, active 1.
address  input  A_SIZE  word address for read and write.
data_in  input  D_SIZE  write data.
byte_en  input  D_SIZE/8  byte write enables; bit k covers data bits [8k+7:8k].
data_out  output  D_SIZE  read data; 0 when data_valid=0.
data_valid  output  1  one-cycle strobe, data_out holds read result.
ready  output  1  1 when clear sweep is done and accesses are accepted.
busy_err  output  1  one-cycle pulse: request arrived while ready=0.

Behaviour:
- Reset (rst_n=0, async):
  - All outputs go to 0: ready, data_valid, data_out, busy_err.
  - Sweep counter goes to 0, FSM enters INIT, read pipeline stages cleared.
  - Array contents are not touched by reset itself.
- FSM INIT:
  - Each cycle writes 0 to memory[cnt], then cnt+1.
  - The cycle cnt==DEPTH-1 is written, FSM moves to READY and ready=1 on the next edge.
  - Sweep takes exactly DEPTH cycles: first rising edge after rst_n release writes word 0, ready visible after edge DEPTH.
- INIT request handling:
  - read/write asserted in INIT are ignored; the array is not modified by the request.
  - busy_err=1 the following cycle, for one cycle per offending cycle.
- FSM READY: stays until the next reset; no other transitions.
- Write (READY, write=1): at the clock edge, for each k with byte_en[k]=1, memory[address] byte k <= data_in byte k. Other bytes are unchanged. byte_en=0 is a no-op.
- Read (READY, read=1) in cycle N:
  - data_valid=1 and data_out=word in cycle N+RD_LATENCY.
  - Both are 0 otherwise.
  - Back-to-back reads are fully pipelined: one result per cycle, in order.
- Read+write same cycle, same address:
  - WRITE_FIRST=1: result = old word merged with the enabled bytes of data_in.
  - WRITE_FIRST=0: result = pre-write word.
  - The array is updated in both cases.
- Different addresses: independent; the read returns the unaffected word.
- Reads issued before a later write to the same address return the value captured at issue; the pipeline holds data, not the address.
- Addresses cover the full DEPTH range; no out-of-range case exists.
- Reset mid-operation:
  - In-flight reads are discarded; no data_valid after reset.
  - Sweep restarts from 0, so all previously written data reads back as 0 after the re-sweep.
- Simultaneous read and write with ready=0: busy_err pulses once; no other effect.

Test Plan:
- Release rst_n, A_SIZE=10 -> ready=0 for 1024 cycles, rises after the 1024th edge; read of addr 0, 511, 1023 returns 0.
- write=1 at cycle 3 after reset release -> busy_err=1 at cycle 4 only. After ready, read of that address returns 0.
- Write 0xDEADBEEF to addr 5 with byte_en=4'b1111, then write 0x0000AB00 with byte_en=4'b0010, then read addr 5 -> data_out=0xDEADABEF with data_valid after RD_LATENCY cycles, for RD_LATENCY=1 and 2.
- Addr 7 holds 0x11111111. Same-cycle read+write of 0x22222222, byte_en=4'b1111:
  - WRITE_FIRST=1 -> 0x22222222;
  - WRITE_FIRST=0 -> 0x11111111;
  - the next read returns 0x22222222 in both cases.
- Four back-to-back reads of addr 1..4 (written 0xA1..0xA4), RD_LATENCY=2 -> data_valid high 4 consecutive cycles, data 0xA1..0xA4 in order.
- Issue a read, assert rst_n=0 the next cycle -> data_valid never rises, ready=0. After re-sweep, addr 5 reads 0.
